secuenciador_nonce: RTL and testbench

Control block that drives the hash-input concatenation stage. It generates the nonce stream plus the two lane round counters (`counter`, `counter_2d`) so the two interleaved hash lanes each latch a distinct nonce once per round period. It also collects the winning nonce reported by the result checker. It sits between the host/job interface and the concatenation stage, and is the issuing end of the nonce/round-counter interface that stage consumes.

---
 rtl/secuenciador_nonce_pkg.sv | 16 +
 rtl/secuenciador_nonce_if.sv | 43 ++++
 rtl/secuenciador_nonce_contador_rondas.sv | 60 ++++++
 rtl/secuenciador_nonce.sv | 160 ++++++++++++++++
 tb/tb_secuenciador_nonce.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/secuenciador_nonce_pkg.sv
// Shared definitions for the nonce sequencer: FSM states, default sizes and lane offset.
package secuenciador_nonce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } estado_e;

  localparam int ROUNDS_DEF  = 64;
  localparam int NONCE_W_DEF = 32;
  // Lane 1 trails lane 0 by this many cycles inside each round period.
  localparam int LANE_OFFSET = 2;

endpackage

// File: rtl/secuenciador_nonce_if.sv
// Job/hit bus between host, result checker and the nonce sequencer.
// With SECUENCIADOR_HASHCOUNT_EN defined the bus also carries hash_count.
interface secuenciador_nonce_if
  import secuenciador_nonce_pkg::*;
#(
  parameter int ROUNDS  = ROUNDS_DEF,
  parameter int NONCE_W = NONCE_W_DEF
);
  localparam int CW = $clog2(ROUNDS);

  logic               start;
  logic [NONCE_W-1:0] nonce_base;
  logic [NONCE_W-1:0] nonce_limit;
  logic               hit_valid;
  logic [NONCE_W-1:0] hit_nonce;
  logic [NONCE_W-1:0] nonce;
  logic [CW-1:0]      counter;
  logic [CW-1:0]      counter_2d;
  logic               busy;
  logic               done;
  logic               found;
  logic [NONCE_W-1:0] nonce_found;
`ifdef SECUENCIADOR_HASHCOUNT_EN
  logic [31:0]        hash_count;
`endif

  modport master (
    output start, nonce_base, nonce_limit, hit_valid, hit_nonce,
    input  nonce, counter, counter_2d, busy, done, found, nonce_found
`ifdef SECUENCIADOR_HASHCOUNT_EN
    , input hash_count
`endif
  );

  modport slave (
    input  start, nonce_base, nonce_limit, hit_valid, hit_nonce,
    output nonce, counter, counter_2d, busy, done, found, nonce_found
`ifdef SECUENCIADOR_HASHCOUNT_EN
    , output hash_count
`endif
  );

endinterface

// File: rtl/secuenciador_nonce_contador_rondas.sv
// Round counters for the two hash lanes plus a registered end-of-period strobe.
module contador_rondas
  import secuenciador_nonce_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF,
  localparam int CW    = $clog2(ROUNDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          load_i,
  output logic [CW-1:0] counter_o,
  output logic [CW-1:0] counter_2d_o,
  output logic          fin_periodo_o
);

  localparam logic [CW-1:0] CNT_CERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_UNO    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX    = CW'(ROUNDS - 1);
  localparam logic [CW-1:0] CNT_2D_INI = CW'(ROUNDS - LANE_OFFSET);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_2d_q, cnt_2d_d;
  logic          fin_q, fin_d;

  // Clear wins over load; otherwise both counters advance and wrap at ROUNDS.
  always_comb begin
    cnt_d    = cnt_q;
    cnt_2d_d = cnt_2d_q;
    if (clr_i) begin
      cnt_d    = CNT_CERO;
      cnt_2d_d = CNT_CERO;
    end else if (load_i) begin
      cnt_d    = CNT_CERO;
      cnt_2d_d = CNT_2D_INI;
    end else begin
      cnt_d    = cnt_q + CNT_UNO;
      cnt_2d_d = cnt_2d_q + CNT_UNO;
    end
    fin_d = (cnt_d == CNT_MAX);
  end

  // Counter registers; the strobe is precomputed so it is high while counter is ROUNDS-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= CNT_CERO;
      cnt_2d_q <= CNT_CERO;
      fin_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      cnt_2d_q <= cnt_2d_d;
      fin_q    <= fin_d;
    end
  end

  assign counter_o     = cnt_q;
  assign counter_2d_o  = cnt_2d_q;
  assign fin_periodo_o = fin_q;

endmodule

// File: rtl/secuenciador_nonce.sv
// Nonce sequencer: issues two nonces per round period to the interleaved hash lanes and
// collects the winning nonce. SECUENCIADOR_HASHCOUNT_EN adds a saturating hash_count output.
module secuenciador_nonce
  import secuenciador_nonce_pkg::*;
#(
  parameter int ROUNDS  = ROUNDS_DEF,
  parameter int NONCE_W = NONCE_W_DEF
) (
  input logic                 clk,
  input logic                 reset,
  secuenciador_nonce_if.slave bus
);

  localparam int CW = $clog2(ROUNDS);
  localparam logic [CW-1:0]      CNT_CERO  = {CW{1'b0}};
  localparam logic [CW-1:0]      CNT_LANE1 = CW'(LANE_OFFSET);
  localparam logic [NONCE_W-1:0] NONCE_CERO = {NONCE_W{1'b0}};
  localparam logic [NONCE_W:0]   UNO_EXT   = {{NONCE_W{1'b0}}, 1'b1};

  estado_e            state_q, state_d;
  // One extra bit so a nonce that runs past all-ones can never satisfy the limit check.
  logic [NONCE_W:0]   nonce_q, nonce_d;
  logic [NONCE_W-1:0] limit_q, limit_d;
  logic [NONCE_W-1:0] nonce_found_q, nonce_found_d;
  logic               found_q, found_d;
  logic               busy_q, done_q;
  logic               cnt_clr_s, cnt_load_s, fin_periodo_s, en_limite_s;
  logic [CW-1:0]      counter_s, counter_2d_s;

  contador_rondas #(.ROUNDS(ROUNDS)) u_contador_rondas (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (cnt_clr_s),
    .load_i       (cnt_load_s),
    .counter_o    (counter_s),
    .counter_2d_o (counter_2d_s),
    .fin_periodo_o(fin_periodo_s)
  );

  assign en_limite_s = ((nonce_q + UNO_EXT) <= {1'b0, limit_q});

  // Next state and nonce datapath; a hit takes priority over the period-end limit check.
  always_comb begin
    state_d       = state_q;
    nonce_d       = nonce_q;
    limit_d       = limit_q;
    found_d       = found_q;
    nonce_found_d = nonce_found_q;
    cnt_clr_s     = 1'b0;
    cnt_load_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d       = ST_RUN;
          nonce_d       = {1'b0, bus.nonce_base};
          limit_d       = bus.nonce_limit;
          found_d       = 1'b0;
          nonce_found_d = NONCE_CERO;
          cnt_load_s    = 1'b1;
        end else begin
          cnt_clr_s = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.hit_valid) begin
          state_d       = ST_DONE;
          found_d       = 1'b1;
          nonce_found_d = bus.hit_nonce;
          cnt_clr_s     = 1'b1;
        end else if ((counter_s == CNT_CERO) || (counter_s == CNT_LANE1)) begin
          nonce_d = nonce_q + UNO_EXT;
        end else if (fin_periodo_s && !en_limite_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (bus.hit_valid) begin
          state_d       = ST_DONE;
          found_d       = 1'b1;
          nonce_found_d = bus.hit_nonce;
          cnt_clr_s     = 1'b1;
        end else if (fin_periodo_s) begin
          state_d   = ST_DONE;
          cnt_clr_s = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        cnt_clr_s = 1'b1;
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_clr_s = 1'b1;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      nonce_q       <= {1'b0, NONCE_CERO};
      limit_q       <= NONCE_CERO;
      found_q       <= 1'b0;
      nonce_found_q <= NONCE_CERO;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      nonce_q       <= nonce_d;
      limit_q       <= limit_d;
      found_q       <= found_d;
      nonce_found_q <= nonce_found_d;
      busy_q        <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q        <= (state_d == ST_DONE);
    end
  end

  assign bus.nonce       = nonce_q[NONCE_W-1:0];
  assign bus.counter     = counter_s;
  assign bus.counter_2d  = counter_2d_s;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.found       = found_q;
  assign bus.nonce_found = nonce_found_q;

`ifdef SECUENCIADOR_HASHCOUNT_EN
  logic [31:0] hash_count_q, hash_count_d;

  // One count per lane capture cycle in RUN, saturating at all-ones.
  always_comb begin
    hash_count_d = hash_count_q;
    if ((state_q == ST_IDLE) && bus.start) begin
      hash_count_d = 32'h0000_0000;
    end else if ((state_q == ST_RUN) &&
                 ((counter_s == CNT_CERO) || (counter_2d_s == CNT_CERO)) &&
                 (hash_count_q != 32'hFFFF_FFFF)) begin
      hash_count_d = hash_count_q + 32'h0000_0001;
    end else begin
      hash_count_d = hash_count_q;
    end
  end

  // Hash counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      hash_count_q <= 32'h0000_0000;
    end else begin
      hash_count_q <= hash_count_d;
    end
  end

  assign bus.hash_count = hash_count_q;
`endif

endmodule

// File: tb/tb_secuenciador_nonce.sv
// Self-checking bench for secuenciador_nonce against a closed-form job timeline model.
module tb_secuenciador_nonce;

  localparam int R = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  secuenciador_nonce_if bus ();
  secuenciador_nonce dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct packed {
    logic [31:0] nonce;
    logic [5:0]  counter;
    logic [5:0]  c2d;
    logic        busy;
    logic        done;
    logic        found;
    logic [31:0] nf;
  } obs_t;

  int n_cmp = 0;
  int n_err = 0;

  // Current job as seen by the model: t = 0 is the first RUN cycle after the start edge.
  longint      j_base, j_limit;
  int          j_p, j_tdone, j_ht;
  logic        j_hit;
  logic [31:0] j_hit_n;

  function automatic obs_t sample();
    obs_t o;
    o.nonce   = bus.nonce;
    o.counter = bus.counter;
    o.c2d     = bus.counter_2d;
    o.busy    = bus.busy;
    o.done    = bus.done;
    o.found   = bus.found;
    o.nf      = bus.nonce_found;
    return o;
  endfunction

  // Periods run while the next pair (N+2, N+3) still fits under the limit.
  function automatic void set_job(input logic [31:0] b, input logic [31:0] l,
                                  input int ht, input logic [31:0] hn);
    j_base  = longint'(b);
    j_limit = longint'(l);
    j_p     = 1;
    while (j_base + 2 * (j_p - 1) + 3 <= j_limit) j_p++;
    j_ht    = ht;
    j_hit_n = hn;
    j_hit   = (ht >= 0) && (ht < (j_p + 1) * R);
    j_tdone = j_hit ? ht + 1 : (j_p + 1) * R;
  endfunction

  function automatic obs_t model(input int t);
    obs_t   e;
    int     tt, p, c;
    longint nv;
    e  = '0;
    tt = (t < j_tdone) ? t : j_tdone - 1;
    p  = tt / R;
    c  = tt % R;
    if (p < j_p) nv = j_base + 2 * p + ((c == 0) ? 0 : ((c <= 2) ? 1 : 2));
    else         nv = j_base + 2 * j_p;
    e.nonce = nv[31:0];
    if (t < j_tdone) begin
      e.counter = 6'(t % R);
      e.c2d     = 6'((t + R - 2) % R);
      e.busy    = 1'b1;
    end
    e.done = (t == j_tdone);
    if (j_hit && (t >= j_tdone)) begin
      e.found = 1'b1;
      e.nf    = j_hit_n;
    end
    return e;
  endfunction

  // Start a job and compare every cycle until one cycle into IDLE; noise adds ignored start/hit pulses.
  task automatic run_job(input logic [31:0] b, input logic [31:0] l, input int ht,
                         input logic [31:0] hn, input bit noise);
    obs_t got, exp;
    set_job(b, l, ht, hn);
    @(negedge clk);
    bus.start = 1'b1; bus.nonce_base = b; bus.nonce_limit = l; bus.hit_valid = 1'b0;
    for (int t = 0; t <= j_tdone + 1; t++) begin
      @(negedge clk);
      got = sample();
      exp = model(t);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL job base=%h t=%0d got=%h exp=%h", b, t, got, exp);
      end
      bus.start       = noise && (t <= j_tdone) && ($urandom_range(0, 7) == 0);
      bus.nonce_base  = $urandom;
      bus.nonce_limit = $urandom;
      bus.hit_valid   = (t == j_ht) || (noise && (t >= j_tdone) && ($urandom_range(0, 1) == 1));
      bus.hit_nonce   = (t == j_ht) ? hn : $urandom;
    end
    bus.start     = 1'b0;
    bus.hit_valid = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    got = sample();
    n_cmp++;
    if (got !== '0) begin n_err++; $display("FAIL reset_state got=%h exp=0", got); end
    reset = 1'b0;
    @(negedge clk);
    got = sample();
    n_cmp++;
    if (got !== '0) begin n_err++; $display("FAIL idle_after_reset got=%h exp=0", got); end
  endtask

  task automatic test_exhaustion();
    run_job(32'h10, 32'h15, -1, 32'h0, 1'b0);
    n_cmp++;
    if ((bus.nonce !== 32'h16) || (bus.found !== 1'b0)) begin
      n_err++;
      $display("FAIL exhaustion_end nonce=%h found=%b exp nonce=16 found=0", bus.nonce, bus.found);
    end
  endtask

  task automatic test_hit();
    run_job(32'h10, 32'h15, 70, 32'h12, 1'b0);
    n_cmp++;
    if ((bus.found !== 1'b1) || (bus.nonce_found !== 32'h12)) begin
      n_err++;
      $display("FAIL hit_hold found=%b nf=%h exp found=1 nf=12", bus.found, bus.nonce_found);
    end
  endtask

  task automatic test_wrap();
    run_job(32'hFFFF_FFFE, 32'hFFFF_FFFF, -1, 32'h0, 1'b0);
    n_cmp++;
    if ((bus.found !== 1'b0) || (bus.busy !== 1'b0)) begin
      n_err++;
      $display("FAIL wrap_end found=%b busy=%b exp 0/0", bus.found, bus.busy);
    end
  endtask

  task automatic test_simultaneous();
    run_job(32'h40, 32'h41, R - 1, 32'hABCD, 1'b1);
    n_cmp++;
    if ((bus.found !== 1'b1) || (bus.nonce_found !== 32'hABCD)) begin
      n_err++;
      $display("FAIL simul_hit found=%b nf=%h exp found=1 nf=abcd", bus.found, bus.nonce_found);
    end
  endtask

  task automatic test_reset_mid_run();
    obs_t got, exp;
    set_job(32'h100, 32'h1FF, -1, 32'h0);
    @(negedge clk);
    bus.start = 1'b1; bus.nonce_base = 32'h100; bus.nonce_limit = 32'h1FF;
    for (int t = 0; t <= 40; t++) begin
      @(negedge clk);
      got = sample();
      exp = model(t);
      n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL pre_reset t=%0d got=%h exp=%h", t, got, exp); end
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 70; i++) begin
      got = sample();
      n_cmp++;
      if (got !== '0) begin n_err++; $display("FAIL reset_mid_run i=%0d got=%h exp=0", i, got); end
      @(negedge clk);
    end
    run_job(32'h100, 32'h103, -1, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] b, l;
    int          ht;
    for (int k = 0; k < 8; k++) begin
      b  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7))) : $urandom;
      l  = b + 32'($urandom_range(0, 9));
      ht = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 400)) : -1;
      run_job(b, l, ht, $urandom, 1'b1);
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.nonce_base  = 32'h0;
    bus.nonce_limit = 32'h0;
    bus.hit_valid   = 1'b0;
    bus.hit_nonce   = 32'h0;
    test_reset();
    test_exhaustion();
    test_hit();
    test_wrap();
    test_reset_mid_run();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
